// File: rtl/nonce_search_ctrl.sv
// Nonce-range search controller: issues nonces to the hasher, tracks in-flight work,
// captures the first matching result, drains outstanding work, then reports the outcome.
// nonce_valid is combinational from state/inflight; every other output is registered.
module nonce_search_ctrl #(
    parameter int NONCE_W      = 32,
    parameter int MAX_INFLIGHT = 64,
    parameter int INF_W        = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               nonce_valid,
    input  logic               nonce_ready,
    input  logic               res_valid,
    input  logic [NONCE_W-1:0] res_nonce,
    input  logic               res_match,
    input  logic [255:0]       res_hash,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic [255:0]       golden_hash,
    output logic [NONCE_W:0]   hashes_done,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FOUND, EXHAUSTED} state_t;

    localparam logic [INF_W-1:0]   INF_ONE  = INF_W'(1);
    localparam logic [INF_W-1:0]   INF_MAX  = INF_W'(MAX_INFLIGHT);
    localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);
    localparam logic [NONCE_W:0]   DONE_ONE = (NONCE_W + 1)'(1);

    state_t             state;
    logic [NONCE_W-1:0] next_nonce;
    logic [NONCE_W-1:0] end_nonce;
    logic [INF_W-1:0]   inflight;
    logic               golden_flag;
    logic               abort_flag;

    logic issue_fire;
    logic res_dec;
    logic match_new;
    logic can_start;
    logic last_issue;

    assign nonce_valid = (state == ISSUE) && (inflight < INF_MAX);
    assign nonce_out   = next_nonce;
    assign issue_fire  = nonce_valid && nonce_ready;
    // A result with nothing in flight is a stray: counted and flagged, never decremented.
    assign res_dec     = res_valid && (inflight != '0);
    // Only results belonging to an active search may become the golden result.
    assign match_new   = res_valid && res_match && !golden_flag &&
                         ((state == ISSUE) || (state == DRAIN));
    assign can_start   = start && ((state == IDLE) || (state == FOUND) || (state == EXHAUSTED));
    assign last_issue  = issue_fire && (next_nonce == end_nonce);

    // Search FSM together with counters, golden capture and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            next_nonce   <= '0;
            end_nonce    <= '0;
            inflight     <= '0;
            hashes_done  <= '0;
            golden_nonce <= '0;
            golden_hash  <= '0;
            golden_flag  <= 1'b0;
            abort_flag   <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
        end else if (can_start) begin
            state        <= ISSUE;
            next_nonce   <= nonce_start;
            end_nonce    <= nonce_end;
            inflight     <= '0;
            hashes_done  <= '0;
            golden_nonce <= '0;
            golden_hash  <= '0;
            golden_flag  <= 1'b0;
            abort_flag   <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
            found        <= 1'b0;
            exhausted    <= 1'b0;
        end else begin
            if (issue_fire && !res_dec) begin
                inflight <= inflight + INF_ONE;
            end else if (!issue_fire && res_dec) begin
                inflight <= inflight - INF_ONE;
            end

            // FOUND/EXHAUSTED freeze the reported count.
            if (res_valid && (state != FOUND) && (state != EXHAUSTED)) begin
                hashes_done <= hashes_done + DONE_ONE;
            end
            if (res_valid && (inflight == '0)) begin
                err <= 1'b1;
            end

            if (match_new) begin
                golden_nonce <= res_nonce;
                golden_hash  <= res_hash;
                golden_flag  <= 1'b1;
            end

            // The final nonce of the range leaves next_nonce parked on it.
            if (issue_fire && !last_issue) begin
                next_nonce <= next_nonce + NONCE_ONE;
            end

            case (state)
                ISSUE: begin
                    if (stop || match_new || last_issue) begin
                        state <= DRAIN;
                        if (stop) begin
                            abort_flag <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && !res_valid) begin
                        busy <= 1'b0;
                        if (golden_flag) begin
                            state <= FOUND;
                            found <= 1'b1;
                        end else if (abort_flag) begin
                            state <= IDLE;
                        end else begin
                            state     <= EXHAUSTED;
                            exhausted <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
